// File: rtl/pulse_detector_mc.sv
// -----------------------------------------------------------------------------
// pulse_detector_mc
//
// Multi-channel edge-triggered pulse generator. Each channel watches one bit of
// sig_in for the edge type selected by edge_mode. After a programmable delay
// (counted in clk cycles) it drives a pulse of programmable length on sig_out.
// An edge that arrives while a channel is busy is dropped and recorded in a
// sticky overrun flag.
//
// Optional feature macro: PULSE_DET_SYNC_EN
//   When defined, a 2-flop synchronizer per channel precedes edge detection so
//   sig_in may be asynchronous. This adds 2 cycles to every latency.
//   When undefined, sig_in must be synchronous to clk.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   synchronous active-high reset
//   sig_in       in   [NUM_CH]   monitored signals
//   delay        in   [DELAY_W]  detect-to-output delay in cycles (shared)
//   pulse_len    in   [LEN_W]    output pulse length in cycles, 0 acts as 1
//   edge_mode    in   [2]        00 rise, 01 fall, 10 both, 11 disabled
//   clr_overrun  in   clears all overrun flags (a same-cycle drop wins)
//   sig_out      out  [NUM_CH]   per-channel output pulse
//   busy         out  [NUM_CH]   channel is in DELAY or PULSE
//   overrun      out  [NUM_CH]   sticky: an edge was dropped while busy
// -----------------------------------------------------------------------------
module pulse_detector_mc #(
  parameter int NUM_CH  = 4,
  parameter int DELAY_W = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_CH-1:0]  sig_in,
  input  logic [DELAY_W-1:0] delay,
  input  logic [LEN_W-1:0]   pulse_len,
  input  logic [1:0]         edge_mode,
  input  logic               clr_overrun,
  output logic [NUM_CH-1:0]  sig_out,
  output logic [NUM_CH-1:0]  busy,
  output logic [NUM_CH-1:0]  overrun
);

  localparam int CNT_W = (DELAY_W > LEN_W) ? DELAY_W : LEN_W;

  // Encoding chosen so that busy is state bit 0 and sig_out is state bit 1:
  // each output comes straight from a single flop and cannot glitch.
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_DELAY = 2'b01;
  localparam logic [1:0] S_PULSE = 2'b11;

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] det_in;

`ifdef PULSE_DET_SYNC_EN
  logic [NUM_CH-1:0] sync_1;
  logic [NUM_CH-1:0] sync_2;

  // NOTE: clocked state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= sig_in;
      sync_2 <= sync_1;
    end
  end

  assign det_in = sync_2;
`else
  assign det_in = sig_in;
`endif

  // ---------------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] prev_in;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic [NUM_CH-1:0] det;

  // prev_in also loads during reset, so an input already high when reset
  // releases is not mistaken for a fresh rising edge.
  always_ff @(posedge clk) begin
    prev_in <= det_in;
  end

  assign rise = det_in & ~prev_in;
  assign fall = ~det_in & prev_in;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    det = '0;
    case (edge_mode)
      MODE_RISE: det = rise;
      MODE_FALL: det = fall;
      MODE_BOTH: det = rise | fall;
      default:   det = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Per-channel FSM
  // ---------------------------------------------------------------------------
  logic [1:0]       state [NUM_CH];
  logic [CNT_W-1:0] cnt   [NUM_CH];
  logic [LEN_W-1:0] len_q [NUM_CH];

  logic [LEN_W-1:0] len_eff;
  logic [CNT_W-1:0] delay_init;
  logic [CNT_W-1:0] len_init;
  logic [NUM_CH-1:0] drop;

  assign len_eff    = (pulse_len == '0) ? LEN_W'(1) : pulse_len;
  assign delay_init = CNT_W'(delay) - CNT_W'(1);
  assign len_init   = CNT_W'(len_eff) - CNT_W'(1);

  always_comb begin
    busy    = '0;
    sig_out = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      busy[ch]    = state[ch][0];
      sig_out[ch] = state[ch][1];
    end
  end

  // An edge seen in any non-IDLE cycle, including the last PULSE cycle, is lost.
  assign drop = det & busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        state[ch] <= S_IDLE;
        cnt[ch]   <= '0;
        len_q[ch] <= '0;
      end
      overrun <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        case (state[ch])
          S_IDLE: begin
            if (det[ch]) begin
              // The pulse length is captured now; the delay is captured in cnt.
              len_q[ch] <= len_eff;
              if (delay == '0) begin
                state[ch] <= S_PULSE;
                cnt[ch]   <= len_init;
              end else begin
                state[ch] <= S_DELAY;
                cnt[ch]   <= delay_init;
              end
            end
          end
          S_DELAY: begin
            if (cnt[ch] == '0) begin
              state[ch] <= S_PULSE;
              cnt[ch]   <= CNT_W'(len_q[ch]) - CNT_W'(1);
            end else begin
              cnt[ch] <= cnt[ch] - CNT_W'(1);
            end
          end
          S_PULSE: begin
            if (cnt[ch] == '0) begin
              state[ch] <= S_IDLE;
            end else begin
              cnt[ch] <= cnt[ch] - CNT_W'(1);
            end
          end
          default: begin
            state[ch] <= S_IDLE;
            cnt[ch]   <= '0;
          end
        endcase
      end
      // Set has priority over clear so a drop coinciding with a clear is kept.
      overrun <= (overrun & ~{NUM_CH{clr_overrun}}) | drop;
    end
  end

endmodule

// File: tb/tb_pulse_detector_mc.sv
// -----------------------------------------------------------------------------
// tb_pulse_detector_mc
//
// Directed self-checking bench for pulse_detector_mc (default build, no
// synchronizer). Inputs change 1 ns after a rising edge; outputs are sampled at
// the same point, so the value seen after a step() is the state after that edge.
// -----------------------------------------------------------------------------
module tb_pulse_detector_mc;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sig_in;
  logic [7:0] delay;
  logic [3:0] pulse_len;
  logic [1:0] edge_mode;
  logic       clr_overrun;
  logic [3:0] sig_out;
  logic [3:0] busy;
  logic [3:0] overrun;

  int checks   = 0;
  int failures = 0;

  pulse_detector_mc #(
    .NUM_CH (4),
    .DELAY_W(8),
    .LEN_W  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sig_in     (sig_in),
    .delay      (delay),
    .pulse_len  (pulse_len),
    .edge_mode  (edge_mode),
    .clr_overrun(clr_overrun),
    .sig_out    (sig_out),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] toggles [5];

  initial begin
    toggles[0] = 4'b1010;
    toggles[1] = 4'b0101;
    toggles[2] = 4'b1111;
    toggles[3] = 4'b0000;
    toggles[4] = 4'b0110;

    reset       = 1'b1;
    sig_in      = 4'b0000;
    delay       = 8'd0;
    pulse_len   = 4'd0;
    edge_mode   = 2'b00;
    clr_overrun = 1'b0;

    // ---------------- reset state ----------------
    step();
    step();
    check("rst_sig_out", 32'(sig_out), 32'h0);
    check("rst_busy",    32'(busy),    32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    reset = 1'b0;
    step();

    // ---------------- basic rise: D=3 L=2 on ch0 ----------------
    edge_mode = 2'b00;
    delay     = 8'd3;
    pulse_len = 4'd2;
    sig_in    = 4'b0001;
    for (int k = 0; k <= 6; k++) begin
      step();  // edge N+k
      check($sformatf("rise_out_k%0d", k),  32'(sig_out), (k == 3 || k == 4) ? 32'h1 : 32'h0);
      check($sformatf("rise_busy_k%0d", k), 32'(busy),    (k <= 4) ? 32'h1 : 32'h0);
    end
    check("rise_overrun", 32'(overrun), 32'h0);

    // ---------------- zero values: fall on ch1, D=0 L=0 ----------------
    edge_mode = 2'b11;
    sig_in    = 4'b0011;
    step();
    step();
    edge_mode = 2'b01;
    delay     = 8'd0;
    pulse_len = 4'd0;
    sig_in    = 4'b0001;  // ch1 falls, ch0 holds
    step();  // N
    check("zero_out_n",   32'(sig_out), 32'h2);
    check("zero_busy_n",  32'(busy),    32'h2);
    step();  // N+1
    check("zero_out_n1",  32'(sig_out), 32'h0);
    check("zero_busy_n1", 32'(busy),    32'h0);

    // ---------------- both edges / overrun on ch2: D=5 L=1 ----------------
    edge_mode = 2'b10;
    delay     = 8'd5;
    pulse_len = 4'd1;
    sig_in    = 4'b0101;  // ch2 rises
    step();  // N
    step();  // N+1
    check("both_ovr_before", 32'(overrun), 32'h0);
    sig_in = 4'b0001;     // ch2 falls, detected at N+2 while busy
    step();  // N+2
    check("both_ovr_set", 32'(overrun), 32'h4);
    for (int k = 3; k <= 6; k++) begin
      step();
      check($sformatf("both_out_k%0d", k), 32'(sig_out), (k == 5) ? 32'h4 : 32'h0);
    end
    check("both_busy_end", 32'(busy), 32'h0);
    check("both_ovr_sticky", 32'(overrun), 32'h4);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'h0);
    sig_in = 4'b0101;     // accepted rise
    step();
    sig_in      = 4'b0001;  // dropped fall together with a clear
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    check("ovr_set_wins", 32'(overrun), 32'h4);
    for (int k = 0; k < 8; k++) step();
    check("both_idle", 32'(busy), 32'h0);

    // ---------------- disable: toggling with edge_mode=11 ----------------
    edge_mode = 2'b11;
    for (int k = 0; k < 5; k++) begin
      sig_in = toggles[k];
      step();
      check($sformatf("dis_out_%0d", k),  32'(sig_out), 32'h0);
      check($sformatf("dis_busy_%0d", k), 32'(busy),    32'h0);
    end
    sig_in = 4'b0000;
    step();

    // ---------------- latch: D=4 changed to 0 and L changed after detect ----
    edge_mode = 2'b00;
    delay     = 8'd4;
    pulse_len = 4'd1;
    sig_in    = 4'b0001;
    step();  // N
    delay     = 8'd0;
    pulse_len = 4'd5;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("latch_out_k%0d", k), 32'(sig_out), (k == 4) ? 32'h1 : 32'h0);
    end

    // ---------------- reset mid-pulse: D=2 L=8 ----------------
    sig_in = 4'b0000;
    step();
    delay     = 8'd2;
    pulse_len = 4'd8;
    sig_in    = 4'b0001;
    step();  // N
    step();  // N+1
    step();  // N+2
    step();  // N+3
    check("rstmid_out_pre", 32'(sig_out), 32'h1);
    reset  = 1'b1;
    sig_in = 4'b1111;
    step();  // N+4
    check("rstmid_out",  32'(sig_out), 32'h0);
    check("rstmid_busy", 32'(busy),    32'h0);
    check("rstmid_ovr",  32'(overrun), 32'h0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("rstrel_busy_%0d", k), 32'(busy),    32'h0);
      check($sformatf("rstrel_out_%0d", k),  32'(sig_out), 32'h0);
    end

    // ---------------- multi-channel: D=1 L=3 ----------------
    sig_in = 4'b0000;
    step();
    delay     = 8'd1;
    pulse_len = 4'd3;
    sig_in    = 4'b1111;
    step();  // N
    check("multi_busy_n", 32'(busy),    32'hF);
    check("multi_out_n",  32'(sig_out), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("multi_out_k%0d", k), 32'(sig_out), (k <= 3) ? 32'hF : 32'h0);
    end
    check("multi_busy_end", 32'(busy),    32'h0);
    check("multi_ovr",      32'(overrun), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
